// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, default frame geometry and
// baud tick divider constants for the 288 MHz clock domain.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam int unsigned DefOversample = 16;
  localparam int unsigned DefDataBits   = 8;
  localparam int unsigned DefStopBits   = 1;

  // 288 MHz / (6 Mbaud * 16) = 3 clocks per oversample tick
  localparam int unsigned ClkFreqHz = 288_000_000;
  localparam int unsigned BaudRate  = 6_000_000;
  localparam int unsigned TickDiv   = ClkFreqHz / (BaudRate * DefOversample);

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at the index just after the last
// winner and wraps modulo NumReq, so the previous winner has lowest priority.
//   req_i      : request vector
//   last_id_i  : index of the previous winner
//   grant_o    : one-hot winner (all zero when no request)
//   grant_id_o : index of the winner
//   valid_o    : at least one request present
module uart_rr_arbiter #(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0]         req_i,
  input  logic [$clog2(NumReq)-1:0] last_id_i,
  output logic [NumReq-1:0]         grant_o,
  output logic [$clog2(NumReq)-1:0] grant_id_o,
  output logic                      valid_o
);

  localparam int unsigned IdW = $clog2(NumReq);

  always_comb begin
    int unsigned idx;
    idx        = 0;
    grant_o    = '0;
    grant_id_o = '0;
    valid_o    = 1'b0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      idx = (32'(last_id_i) + off) % NumReq;
      if (!valid_o && req_i[idx]) begin
        valid_o      = 1'b1;
        grant_id_o   = IdW'(idx);
        grant_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX line between NUM_REQ byte requesters.
// On each frame start the baud tick generator is phase-restarted via baudReset so bit
// boundaries line up with the grant. Ticks are counted to shift out start, data (LSB
// first) and stop bits.
//   CLK288MHZ : system clock        resetN    : async active-low reset
//   req       : per-requester level request, held until granted
//   data      : byte i at [i*DATA_BITS +: DATA_BITS], sampled only at the grant edge
//   tick      : oversample tick from the baud generator
//   baudReset : one-cycle phase restart to the baud generator
//   grant     : one-cycle one-hot accept pulse
//   grantId   : index of the last granted requester
//   busy      : frame in progress
//   txd       : serial line, idle high
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned OVERSAMPLE = DefOversample,
  parameter int unsigned DATA_BITS  = DefDataBits,
  parameter int unsigned STOP_BITS  = DefStopBits
) (
  input  logic                         CLK288MHZ,
  input  logic                         resetN,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_BITS-1:0] data,
  input  logic                         tick,
  output logic                         baudReset,
  output logic [NUM_REQ-1:0]           grant,
  output logic [$clog2(NUM_REQ)-1:0]   grantId,
  output logic                         busy,
  output logic                         txd
);

  localparam int unsigned IdW   = $clog2(NUM_REQ);
  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [TickW-1:0]     tick_cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IdW-1:0]       grant_id_q;
  logic                 baud_reset_q;
  logic                 busy_q;
  logic                 txd_q;

  logic [NUM_REQ-1:0]   win_oh;
  logic [IdW-1:0]       win_id;
  logic                 win_valid;
  logic                 tick_ok;
  logic                 bit_end;

  uart_rr_arbiter #(
    .NumReq (NUM_REQ)
  ) u_arb (
    .req_i      (req),
    .last_id_i  (grant_id_q),
    .grant_o    (win_oh),
    .grant_id_o (win_id),
    .valid_o    (win_valid)
  );

  // A tick arriving while the generator is being restarted belongs to the old phase.
  always_comb begin
    tick_ok = tick && !baud_reset_q && (state_q != StIdle);
    bit_end = tick_ok && (tick_cnt_q == TickW'(OVERSAMPLE - 1));
  end

  always_ff @(posedge CLK288MHZ or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      grant_q      <= '0;
      grant_id_q   <= IdW'(NUM_REQ - 1);
      baud_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      txd_q        <= 1'b1;
    end else begin
      grant_q      <= '0;
      baud_reset_q <= 1'b0;

      if (tick_ok) begin
        tick_cnt_q <= bit_end ? '0 : tick_cnt_q + TickW'(1);
      end

      unique case (state_q)
        StIdle: begin
          tick_cnt_q <= '0;
          bit_cnt_q  <= '0;
          if (win_valid) begin
            shift_q      <= data[win_id*DATA_BITS +: DATA_BITS];
            grant_id_q   <= win_id;
            grant_q      <= win_oh;
            baud_reset_q <= 1'b1;
            txd_q        <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            txd_q     <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= StData;
          end
        end
        StData: begin
          if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
              txd_q     <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= StStop;
            end else begin
              // shift_q[1] is the bit that becomes shift_q[0] after this shift
              txd_q     <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
          end
        end
        StStop: begin
          if (bit_end) begin
            if (bit_cnt_q == BitW'(STOP_BITS - 1)) begin
              bit_cnt_q <= '0;
              busy_q    <= 1'b0;
              state_q   <= StIdle;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
          end
        end
      endcase
    end
  end

  assign baudReset = baud_reset_q;
  assign grant     = grant_q;
  assign grantId   = grant_id_q;
  assign busy      = busy_q;
  assign txd       = txd_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched with a behavioural baud generator: one tick every
// 3 clocks, restarted by baudReset, so the first tick of a frame lands 4 edges after E.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        resetN;
  logic [3:0]  req;
  logic [31:0] data;
  logic        tick;
  logic        baudReset;
  logic [3:0]  grant;
  logic [1:0]  grantId;
  logic        busy;
  logic        txd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] gen_cnt;
  logic       txd_s   [490];
  logic       busy_s  [490];
  logic       baud_s  [490];
  logic [3:0] grant_s [490];

  uart_tx_sched #(
    .NUM_REQ    (4),
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .STOP_BITS  (1)
  ) dut (
    .CLK288MHZ (clk),
    .resetN    (resetN),
    .req       (req),
    .data      (data),
    .tick      (tick),
    .baudReset (baudReset),
    .grant     (grant),
    .grantId   (grantId),
    .busy      (busy),
    .txd       (txd)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      gen_cnt <= 2'd0;
      tick    <= 1'b0;
    end else if (baudReset) begin
      gen_cnt <= 2'd0;
      tick    <= 1'b0;
    end else begin
      tick    <= (gen_cnt == 2'd1);
      gen_cnt <= (gen_cnt == 2'd2) ? 2'd0 : gen_cnt + 2'd1;
    end
  end

  // Records one frame; sample 0 is the cycle after the grant edge. Optionally changes
  // req/data at sample disturb_at.
  task automatic capture(input int disturb_at, input logic [3:0] new_req,
                         input logic [31:0] new_data);
    for (int i = 0; i < 490; i++) begin
      @(negedge clk);
      txd_s[i]   = txd;
      busy_s[i]  = busy;
      baud_s[i]  = baudReset;
      grant_s[i] = grant;
      if (i == 0) req = '0;
      if (i == disturb_at) begin
        req  = new_req;
        data = new_data;
      end
    end
  endtask

  task automatic send_frame(input logic [3:0] r, input logic [31:0] d,
                            output logic [3:0] g, output logic [1:0] id, output bit to);
    int n;
    to = 1'b0;
    g  = '0;
    id = '0;
    @(negedge clk);
    req  = r;
    data = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == 4'b0 && n < 700);
    if (grant == 4'b0) to = 1'b1;
    else begin
      g  = grant;
      id = grantId;
    end
    req = '0;
    n = 0;
    while (busy !== 1'b0 && n < 700) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) to = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 700) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b1;
    req    = '0;
    data   = '0;
    #2 resetN = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (txd !== 1'b1) begin n_fail++; $display("FAIL rst_txd: got %b want 1", txd); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++;
    if (grant !== 4'b0) begin n_fail++; $display("FAIL rst_grant: got %b want 0", grant); end
    n_checks++;
    if (baudReset !== 1'b0) begin
      n_fail++; $display("FAIL rst_baud: got %b want 0", baudReset);
    end
    n_checks++;
    if (grantId !== 2'd3) begin n_fail++; $display("FAIL rst_id: got %0d want 3", grantId); end
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [7:0] b;
    int cnt, bad;
    b = 8'hA5;
    @(negedge clk);
    req  = 4'b0001;
    data = 32'h0000_00A5;
    capture(-1, 4'b0, 32'h0);
    n_checks++;
    if (grant_s[0] !== 4'b0001) begin
      n_fail++; $display("FAIL sf_grant: got %b want 0001", grant_s[0]);
    end
    n_checks++;
    if (baud_s[0] !== 1'b1) begin n_fail++; $display("FAIL sf_baud: got %b want 1", baud_s[0]); end
    cnt = 0;
    for (int i = 0; i < 490; i++) if (grant_s[i] != 4'b0) cnt++;
    n_checks++;
    if (cnt != 1) begin n_fail++; $display("FAIL sf_grant_len: got %0d want 1", cnt); end
    cnt = 0;
    for (int i = 0; i < 490; i++) if (baud_s[i] === 1'b1) cnt++;
    n_checks++;
    if (cnt != 1) begin n_fail++; $display("FAIL sf_baud_len: got %0d want 1", cnt); end
    n_checks++;
    if (grantId !== 2'd0) begin n_fail++; $display("FAIL sf_id: got %0d want 0", grantId); end
    cnt = 0;
    while (cnt < 490 && txd_s[cnt] === 1'b0) cnt++;
    n_checks++;
    if (cnt != 49) begin n_fail++; $display("FAIL sf_start_len: got %0d want 49", cnt); end
    for (int k = 0; k < 8; k++) begin
      bad = 0;
      for (int j = 0; j < 48; j++) if (txd_s[49 + 48*k + j] !== b[k]) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL sf_bit%0d: %0d samples wrong, want %b", k, bad, b[k]);
      end
    end
    bad = 0;
    for (int i = 433; i < 490; i++) if (txd_s[i] !== 1'b1) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL sf_stop: %0d low samples, want 0", bad); end
    cnt = 0;
    for (int i = 0; i < 490; i++) if (busy_s[i] === 1'b1) cnt++;
    n_checks++;
    if (cnt != 481 || busy_s[480] !== 1'b1) begin
      n_fail++; $display("FAIL sf_busy_len: got %0d want 481", cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    logic [1:0] exp_id [5];
    logic [3:0] g;
    logic [1:0] id;
    bit to;
    exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_frame(4'b1111, 32'h1122_3344, g, id, to);
      n_checks++;
      if (g !== exp_g[i] || to) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b want %b", i, g, exp_g[i]);
      end
      n_checks++;
      if (id !== exp_id[i]) begin
        n_fail++; $display("FAIL rr_id%0d: got %0d want %0d", i, id, exp_id[i]);
      end
    end
  endtask

  task automatic test_wrap_skip();
    logic [3:0] g;
    logic [1:0] id;
    bit to;
    send_frame(4'b0100, 32'h0000_0000, g, id, to);
    n_checks++;
    if (g !== 4'b0100 || id !== 2'd2) begin
      n_fail++; $display("FAIL ws_setup: got %b/%0d want 0100/2", g, id);
    end
    send_frame(4'b0011, 32'h0000_0000, g, id, to);
    n_checks++;
    if (g !== 4'b0001 || id !== 2'd0) begin
      n_fail++; $display("FAIL ws_wrap: got %b/%0d want 0001/0", g, id);
    end
    send_frame(4'b0010, 32'h0000_0000, g, id, to);
    n_checks++;
    if (g !== 4'b0010 || id !== 2'd1) begin
      n_fail++; $display("FAIL ws_next: got %b/%0d want 0010/1", g, id);
    end
  endtask

  task automatic test_mid_frame();
    logic [7:0] b;
    int bad, cnt;
    b = 8'h96;
    @(negedge clk);
    req  = 4'b0001;
    data = 32'h0000_0096;
    capture(150, 4'b1110, 32'hFFFF_FFFF);
    bad = 0;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 48; j++) if (txd_s[49 + 48*k + j] !== b[k]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL mf_bits: %0d samples wrong, want 0", bad); end
    cnt = 0;
    for (int i = 1; i < 482; i++) if (grant_s[i] != 4'b0) cnt++;
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("FAIL mf_no_grant: got %0d want 0", cnt); end
    n_checks++;
    if (grant_s[482] !== 4'b0010) begin
      n_fail++; $display("FAIL mf_next_grant: got %b want 0010", grant_s[482]);
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_async_reset();
    logic [3:0] g;
    logic [1:0] id;
    bit to;
    @(negedge clk);
    req  = 4'b0001;
    data = 32'h0000_0000;
    @(negedge clk);
    req = '0;
    repeat (199) @(negedge clk);
    n_checks++;
    if (txd !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL ar_pre: txd/busy %b/%b want 0/1", txd, busy);
    end
    resetN = 1'b0;
    #1;
    n_checks++;
    if (txd !== 1'b1) begin n_fail++; $display("FAIL ar_txd: got %b want 1", txd); end
    n_checks++;
    if (busy !== 1'b0 || grant !== 4'b0) begin
      n_fail++; $display("FAIL ar_busy_grant: got %b/%b want 0/0000", busy, grant);
    end
    n_checks++;
    if (grantId !== 2'd3) begin n_fail++; $display("FAIL ar_id: got %0d want 3", grantId); end
    @(negedge clk);
    resetN = 1'b1;
    send_frame(4'b1000, 32'h5A00_0000, g, id, to);
    n_checks++;
    if (g !== 4'b1000 || id !== 2'd3 || to) begin
      n_fail++; $display("FAIL ar_after: got %b/%0d want 1000/3", g, id);
    end
  endtask

  task automatic test_back_to_back();
    int n, hi_run, gap;
    @(negedge clk);
    req  = 4'b0011;
    data = 32'h0000_3C3C;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == 4'b0 && n < 700);
    n_checks++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL bb_first: got %b want 0001", grant); end
    n = 0;
    hi_run = 0;
    while (busy === 1'b1 && n < 700) begin
      @(negedge clk);
      n++;
      hi_run = (txd === 1'b1) ? hi_run + 1 : 0;
    end
    gap = 0;
    while (busy !== 1'b1 && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    n_checks++;
    if (gap != 1) begin n_fail++; $display("FAIL bb_gap: got %0d want 1", gap); end
    n_checks++;
    if (hi_run != 49) begin n_fail++; $display("FAIL bb_high_run: got %0d want 49", hi_run); end
    n_checks++;
    if (grant !== 4'b0010 || txd !== 1'b0) begin
      n_fail++; $display("FAIL bb_second: grant/txd %b/%b want 0010/0", grant, txd);
    end
    req = '0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_wrap_skip();
    test_mid_frame();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Shares one 6 Mbaud UART transmit line between NUM_REQ byte requesters using round-robin arbitration. Sequences the oversampling baud tick generator: issues a one-cycle baudReset at each frame start so bit phase is aligned to the grant. Counts generator ticks to shift out start, data (LSB first) and stop bits on txd. Sits between the byte producers, the baud tick generator and the TX pin in the 288 MHz domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
OVERSAMPLE, 16, baud ticks per UART bit
DATA_BITS, 8, data bits per frame
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
CLK288MHZ  input  1  system clock, all logic on rising edge
resetN  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester send request, level, held until granted
data  input  NUM_REQ*DATA_BITS  byte of requester i at bits [i*DATA_BITS +: DATA_BITS]
tick  input  1  oversample tick from baud generator, 1-cycle pulses
baudReset  output  1  phase-restart pulse to baud generator
grant  output  NUM_REQ  one-hot, one-cycle accept pulse
grantId  output  $clog2(NUM_REQ)  index of last granted requester
busy  output  1  frame in progress
txd  output  1  serial line, idle high

Behaviour:
- All outputs registered. Reset values: txd=1, busy=0, grant=0, baudReset=0, grantId=NUM_REQ-1 (requester 0 wins first), state IDLE, counters 0.
- States: IDLE, START, DATA, STOP.
- IDLE: at edge E with req!=0, winner = first asserted index after grantId, wrapping modulo NUM_REQ. At E: latch data[winner] into shift register, grantId<=winner, grant[winner]<=1, baudReset<=1, txd<=0, busy<=1, state<=START. Cycle after E is G. grant and baudReset high only during G.
- Requester deasserts req after seeing grant. A req still high when IDLE is re-entered is a new request.
- Tick counting: tick is ignored in any cycle where baudReset=1. A tick increments tickCnt (0..OVERSAMPLE-1). On the OVERSAMPLE-th tick of a bit, tickCnt<=0 and the bit advances at that edge.
- START -> DATA: txd<=shift[0], bitCnt<=0.
- DATA: each bit end shifts right. After DATA_BITS bits, txd<=1 and state<=STOP.
- STOP: lasts STOP_BITS*OVERSAMPLE ticks. At its final tick: state<=IDLE, busy<=0.
- Arbitration resumes at the first edge in IDLE, so there is 1 extra idle-high cycle between back-to-back frames.
- req changes during a frame have no effect. data is sampled only at edge E.
- Async reset mid-frame: txd immediately 1, frame aborted, grant/busy cleared, grantId=NUM_REQ-1.
- Width rules: tickCnt is $clog2(OVERSAMPLE) bits. bitCnt is $clog2(DATA_BITS+1) bits. No overflow possible.

Decomposition:
- Shared package uart_pkg: state enum (IDLE/START/DATA/STOP), default OVERSAMPLE=16, DATA_BITS=8, tick-divider constants.
- One sub-module: uart_rr_arbiter. It takes req and last grantId and produces a combinational one-hot winner and index. It is reused by the RX-side FIFO readout.

Test Plan:
- Test setup: tick driven by the real baud generator, one tick per 3 clocks. baudReset is fed back to it; OVERSAMPLE=16.
- Single frame: req=0001, data[0]=0xA5 -> grant=0001 and baudReset for exactly 1 cycle. txd low 49 cycles (start), then bits 1,0,1,0,0,1,0,1 of 48 cycles each, then stop high 48 cycles. busy high for 481 cycles total.
- Round-robin: req=1111 held and re-asserted after each grant -> grants in order 0,1,2,3,0. grantId follows.
- Wrap / skip: grantId=2, req=0011 -> grant=0001. Then req=0010 -> grant=0010.
- Mid-frame disturbance: data and req change during DATA -> txd bits unchanged from the byte latched at E. No grant until busy=0.
- Async reset: resetN low at cycle 200 of a frame -> txd=1, busy=0, grant=0 in the same cycle. After release, req=1000 -> grant=1000 (grantId reset to 3, so the scan starts at index 0 and the lone request 3 wins).
- Back-to-back: two requesters with continuous req -> exactly 1 idle-high cycle between the stop bit end and the next start bit.
